// File: rtl/risc_v_32_pkg.sv
// Shared definitions for the RV32 instruction memory: the canonical NOP
// (addi x0,x0,0) returned on any non-fetch, and the loader FSM state encoding.
package risc_v_32_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } imem_state_e;

endpackage

// File: rtl/risc_v_32_imem_loader.sv
// Little-endian byte assembler for the instruction-memory loader: counts bytes
// within a word, collects the lower three and presents full or zero-padded words.
module risc_v_32_imem_loader (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  input  logic        i_flush,
  output logic        o_word_done,
  output logic [31:0] o_word,
  output logic [31:0] o_pad_word,
  output logic [1:0]  o_cnt_next
);

  logic [1:0]  r_cnt;
  logic [23:0] r_data;

  // The 4th byte is never registered: it goes straight into the word being written.
  assign o_word_done = i_accept && (r_cnt == 2'd3);
  assign o_word      = {i_byte, r_data};
  assign o_pad_word  = {8'h00, r_data};
  assign o_cnt_next  = i_accept ? r_cnt + 2'd1 : r_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clrn) begin
      r_cnt  <= 2'd0;
      r_data <= 24'h0;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else if (i_accept) begin
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_data <= {16'h0000, i_byte};  // clearing here yields the zero pad
        2'd1:    r_data[15:8]  <= i_byte;
        2'd2:    r_data[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/risc_v_32_imem.sv
// RV32 instruction memory with zero-latency fetch and a byte-serial program
// loader. Define IMEM_BOUNDS_CHECK_EN to flag fetches beyond DEPTH_WORDS as faults.
module risc_v_32_imem
  import risc_v_32_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic [31:0]                 pc,
  output logic [31:0]                 inst,
  output logic                        inst_valid,
  output logic                        misalign,
  output logic                        fault,
  input  logic                        ld_valid,
  input  logic [7:0]                  ld_byte,
  output logic                        ld_ready,
  input  logic                        ld_done,
  output logic                        busy,
  output logic [$clog2(DEPTH_WORDS):0] ld_count,
  output logic                        ld_overflow
);

  localparam int AW = $clog2(DEPTH_WORDS);

  imem_state_e r_state, w_state_nxt;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [AW:0] r_wptr;
  logic        r_ovf;

  logic        w_full, w_accept, w_we, w_fetch_ok;
  logic        w_word_done;
  logic [31:0] w_word, w_pad_word, w_wdata;
  logic [1:0]  w_cnt_next;
  logic [AW-1:0] w_idx;

  // wptr only counts up to DEPTH_WORDS, so its top bit is exactly "full".
  assign w_full   = r_wptr[AW];
  assign w_accept = ld_valid && ld_ready;

  // RUN always accepts: the first byte restarts the load and clears wptr anyway.
  always_comb begin
    ld_ready = 1'b0;
    case (r_state)
      ST_RUN:  ld_ready = 1'b1;
      ST_LOAD: ld_ready = !w_full;
      default: ld_ready = 1'b0;
    endcase
  end

  risc_v_32_imem_loader u_loader (
    .clk         (clk),
    .clrn        (clrn),
    .i_accept    (w_accept),
    .i_byte      (ld_byte),
    .i_flush     (r_state == ST_FLUSH),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_pad_word  (w_pad_word),
    .o_cnt_next  (w_cnt_next)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (ld_done) w_state_nxt = (w_cnt_next == 2'd0) ? ST_RUN : ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  assign w_we    = (w_accept && w_word_done) || (r_state == ST_FLUSH);
  assign w_wdata = (r_state == ST_FLUSH) ? w_pad_word : w_word;

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_wptr <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == ST_RUN && w_accept) begin
      r_wptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_we)
        r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (r_state == ST_LOAD && ld_valid && w_full)
        r_ovf <= 1'b1;
    end
  end

  // NOTE: storage has no reset so it maps onto RAM and loaded words survive clrn.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[r_wptr[AW-1:0]] <= w_wdata;
  end

  assign misalign = (pc[1:0] != 2'b00);
  assign w_idx    = pc[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fault = (pc[31:AW+2] != '0);
`else
  logic w_unused_pc_hi;
  assign w_unused_pc_hi = ^pc[31:AW+2];
  assign fault          = 1'b0;
`endif

  assign w_fetch_ok  = (r_state == ST_RUN) && !misalign && !fault;
  assign inst        = w_fetch_ok ? r_mem[w_idx] : NOP;
  assign inst_valid  = w_fetch_ok;
  assign busy        = (r_state != ST_RUN);
  assign ld_count    = r_wptr;
  assign ld_overflow = r_ovf;

endmodule

// File: tb/tb_risc_v_32_imem.sv
// Directed testbench for risc_v_32_imem: a 1024-word instance for load/fetch
// behaviour and a 4-word instance for the full-memory and bounds cases.
module tb_risc_v_32_imem;

  localparam int BIG_AW   = 10;
  localparam int SMALL_AW = 2;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic [31:0]     b_pc, b_inst;
  logic            b_inst_valid, b_misalign, b_fault;
  logic            b_ld_valid, b_ld_ready, b_ld_done, b_busy, b_ld_overflow;
  logic [7:0]      b_ld_byte;
  logic [BIG_AW:0] b_ld_count;

  logic [31:0]       s_pc, s_inst;
  logic              s_inst_valid, s_misalign, s_fault;
  logic              s_ld_valid, s_ld_ready, s_ld_done, s_busy, s_ld_overflow;
  logic [7:0]        s_ld_byte;
  logic [SMALL_AW:0] s_ld_count;

  risc_v_32_imem #(.DEPTH_WORDS(1024)) u_big (
    .clk(clk), .clrn(clrn), .pc(b_pc), .inst(b_inst), .inst_valid(b_inst_valid),
    .misalign(b_misalign), .fault(b_fault), .ld_valid(b_ld_valid), .ld_byte(b_ld_byte),
    .ld_ready(b_ld_ready), .ld_done(b_ld_done), .busy(b_busy), .ld_count(b_ld_count),
    .ld_overflow(b_ld_overflow)
  );

  risc_v_32_imem #(.DEPTH_WORDS(4)) u_small (
    .clk(clk), .clrn(clrn), .pc(s_pc), .inst(s_inst), .inst_valid(s_inst_valid),
    .misalign(s_misalign), .fault(s_fault), .ld_valid(s_ld_valid), .ld_byte(s_ld_byte),
    .ld_ready(s_ld_ready), .ld_done(s_ld_done), .busy(s_busy), .ld_count(s_ld_count),
    .ld_overflow(s_ld_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    b_ld_valid = 1'b1;
    b_ld_byte  = b;
    tick();
    b_ld_valid = 1'b0;
  endtask

  task automatic pulse_done();
    b_ld_done = 1'b1;
    tick();
    b_ld_done = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    b_pc = addr;
    #1;
    check(tag, b_inst, exp);
  endtask

  logic [7:0] prog_a [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] prog_b [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

  initial begin
    int n_acc;
    clrn = 1'b1;
    b_pc = '0; b_ld_valid = 1'b0; b_ld_byte = '0; b_ld_done = 1'b0;
    s_pc = '0; s_ld_valid = 1'b0; s_ld_byte = '0; s_ld_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b0;

    // Reset state
    check("rst_busy", 32'(b_busy), 32'd0);
    check("rst_count", 32'(b_ld_count), 32'd0);
    check("rst_ovf", 32'(b_ld_overflow), 32'd0);
    check("rst_ready", 32'(b_ld_ready), 32'd1);

    // Two-word program, aligned end
    send_byte(prog_a[0]);
    check("load_busy", 32'(b_busy), 32'd1);
    check("load_inst_valid", 32'(b_inst_valid), 32'd0);
    check("load_inst_nop", b_inst, 32'h0000_0013);
    for (int i = 1; i < 8; i++) send_byte(prog_a[i]);
    check("a_count_pre_done", 32'(b_ld_count), 32'd2);
    pulse_done();
    check("a_busy_after_done", 32'(b_busy), 32'd0);
    check("a_count", 32'(b_ld_count), 32'd2);
    fetch("a_word0", 32'd0, 32'h0000_0013);
    fetch("a_word1", 32'd4, 32'h0010_0093);
    check("a_valid", 32'(b_inst_valid), 32'd1);

    // Misaligned fetch
    b_pc = 32'd2;
    #1;
    check("mis_flag", 32'(b_misalign), 32'd1);
    check("mis_inst", b_inst, 32'h0000_0013);
    check("mis_valid", 32'(b_inst_valid), 32'd0);

    // Five bytes -> partial word flushed with zero pad
    for (int i = 0; i < 5; i++) send_byte(prog_b[i]);
    pulse_done();
    check("flush_busy", 32'(b_busy), 32'd1);
    check("flush_ready", 32'(b_ld_ready), 32'd0);
    tick();
    check("b_busy_after_flush", 32'(b_busy), 32'd0);
    check("b_count", 32'(b_ld_count), 32'd2);
    fetch("b_word0", 32'd0, 32'hDDCC_BBAA);
    fetch("b_word1", 32'd4, 32'h0000_00EE);

    // 4th byte and ld_done together: byte taken first, no flush
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    b_ld_done = 1'b1;
    send_byte(8'h44);
    b_ld_done = 1'b0;
    check("same_cycle_busy", 32'(b_busy), 32'd0);
    check("same_cycle_count", 32'(b_ld_count), 32'd1);
    fetch("same_cycle_word0", 32'd0, 32'h4433_2211);

    // Reset mid-load: word 0 kept, partial discarded, word 1 untouched
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
    check("mid_rst_busy", 32'(b_busy), 32'd0);
    check("mid_rst_count", 32'(b_ld_count), 32'd0);
    fetch("mid_rst_word0", 32'd0, 32'h0403_0201);
    fetch("mid_rst_word1", 32'd4, 32'h0000_00EE);

    // A fresh one-byte load must start at byte 0 again
    send_byte(8'h7F);
    pulse_done();
    tick();
    check("post_rst_count", 32'(b_ld_count), 32'd1);
    fetch("post_rst_word0", 32'd0, 32'h0000_007F);

    // 4-word memory: 17 bytes offered, 16 accepted
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      s_ld_valid = 1'b1;
      s_ld_byte  = 8'(16 + i);
      if (s_ld_ready) n_acc++;
      tick();
    end
    s_ld_valid = 1'b0;
    check("full_accepted", 32'(n_acc), 32'd16);
    check("full_ready", 32'(s_ld_ready), 32'd0);
    check("full_ovf", 32'(s_ld_overflow), 32'd1);
    check("full_count", 32'(s_ld_count), 32'd4);
    s_ld_done = 1'b1;
    tick();
    s_ld_done = 1'b0;
    check("full_busy_after_done", 32'(s_busy), 32'd0);
    check("full_ovf_sticky", 32'(s_ld_overflow), 32'd1);
    s_pc = 32'd12;
    #1;
    check("full_word3", s_inst, 32'h1F1E_1D1C);
    s_pc = 32'd16;
    #1;
`ifdef IMEM_BOUNDS_CHECK_EN
    check("oob_fault", 32'(s_fault), 32'd1);
    check("oob_inst", s_inst, 32'h0000_0013);
    check("oob_valid", 32'(s_inst_valid), 32'd0);
`else
    check("oob_fault", 32'(s_fault), 32'd0);
    check("oob_wrap_inst", s_inst, 32'h1312_1110);
    check("oob_valid", 32'(s_inst_valid), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
